fx_mul: RTL and testbench

- Pipelined signed fixed-point multiplier, Q(QINT).(QFRAC) format, with valid/ready flow control on both sides.
- Computes result = a*b, rescaled to the same Q format with rounding and saturation.
- Arithmetic leaf used by datapath steps such as the LSM continuation-value polynomial; multiple instances are chained and share downstream ready.

---
 rtl/fx_mul.sv | 136 +++++++++++++
 tb/tb_fx_mul.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_mul.sv
// fx_mul: three-stage pipelined signed fixed-point multiplier, Q(QINT).(QFRAC).
// Valid/ready on both sides: a beat transfers on a rising edge when the
// producer's valid and the consumer's ready are both high; a producer holds its
// data stable until that transfer occurs, and ready never waits on valid.
// Stages: S1 operand capture, S2 full-precision product, S3 rounded/saturated
// result register driving valid_out/result.

package fpga_cfg_pkg;
    localparam int FP_WIDTH = 32;
    localparam int FP_QINT  = 16;
    localparam int FP_QFRAC = 16;
endpackage

module fx_mul #(
    parameter int WIDTH = fpga_cfg_pkg::FP_WIDTH,
    parameter int QINT  = fpga_cfg_pkg::FP_QINT,
    parameter int QFRAC = fpga_cfg_pkg::FP_QFRAC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic signed [WIDTH-1:0] result
);

    // One extra bit over the full product so the rounding add cannot overflow.
    localparam int PW = 2 * WIDTH;
    localparam int LW = PW + 1;

    localparam logic signed [LW-1:0] RND_HALF = LW'(1) << (QFRAC - 1);
    localparam logic signed [LW-1:0] SAT_MAX  = (LW'(1) << (WIDTH - 1)) - LW'(1);
    localparam logic signed [LW-1:0] SAT_MIN  = -(LW'(1) << (WIDTH - 1));

    if ((QINT + QFRAC != WIDTH) || (QFRAC < 1)) begin : g_bad_cfg
        $error("fx_mul: QINT+QFRAC must equal WIDTH and QFRAC must be >= 1");
    end

    // Stage registers
    logic                    r_s1_valid;
    logic signed [WIDTH-1:0] r_a;
    logic signed [WIDTH-1:0] r_b;
    logic                    r_s2_valid;
    logic signed [PW-1:0]    r_prod;
    logic                    r_s3_valid;
    logic signed [WIDTH-1:0] r_result;

    // Stage load enables: a stage loads when empty or when it drains this cycle
    logic w_s1_load;
    logic w_s2_load;
    logic w_s3_load;

    // Datapath wires
    logic signed [PW-1:0]    w_a_ext;
    logic signed [PW-1:0]    w_b_ext;
    logic signed [PW-1:0]    w_prod;
    logic signed [LW-1:0]    w_prod_ext;
    logic signed [LW-1:0]    w_rnd;
    logic signed [LW-1:0]    w_shift;
    logic signed [WIDTH-1:0] w_sat;

    assign w_s3_load = !r_s3_valid || ready_in;
    assign w_s2_load = !r_s2_valid || w_s3_load;
    assign w_s1_load = !r_s1_valid || w_s2_load;

    // No acceptance while reset is held, so nothing is lost at the reset edge.
    assign ready_out = rst_n && w_s1_load;

    assign valid_out = r_s3_valid;
    assign result    = r_result;

    // Sign-extend both operands so the truncated product keeps full precision.
    assign w_a_ext = {{WIDTH{r_a[WIDTH-1]}}, r_a};
    assign w_b_ext = {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Round half toward +infinity, then drop the extra fractional bits.
    assign w_prod_ext = {r_prod[PW-1], r_prod};
    assign w_rnd      = w_prod_ext + RND_HALF;
    assign w_shift    = w_rnd >>> QFRAC;

    // Clamp the rescaled product to the representable range.
    always_comb begin
        w_sat = w_shift[WIDTH-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[WIDTH-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[WIDTH-1:0];
        end
    end

    // S1: capture the operand pair on an input transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_a <= a;
                r_b <= b;
            end
        end
    end

    // S2: register the full 2*WIDTH signed product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_prod     <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_prod <= w_prod;
            end
        end
    end

    // S3: output register; result keeps its last value when no product arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_result   <= '0;
        end else if (w_s3_load) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_result <= w_sat;
            end
        end
    end

endmodule

// File: tb/tb_fx_mul.sv
// tb_fx_mul: randomized and directed stimulus for fx_mul, scoreboard checked
// against an arithmetic reference model of the Q16.16 multiply.
module tb_fx_mul;
  localparam int W = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                valid_in;
  logic                ready_out;
  logic [W-1:0]        a;
  logic [W-1:0]        b;
  logic                valid_out;
  logic                ready_in;
  logic signed [W-1:0] result;

  // clock / reset
  always #5 clk = ~clk;

  fx_mul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .a         (a),
    .b         (b),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .result    (result)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           run_len = 0;
  int           max_run = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_result = '0;
  bit           rnd_done = 1'b0;

  // directed table: operands and the expected results worked out by hand
  logic [W-1:0] dir_a[8] = '{32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                             32'h8000_0000, 32'h8000_0000, 32'hFFFE_8000, 32'h0001_8000};
  logic [W-1:0] dir_b[8] = '{32'h0000_8000, 32'h0000_7FFF, 32'h0000_8000, 32'h7FFF_FFFF,
                             32'h7FFF_FFFF, 32'h8000_0000, 32'h0002_0000, 32'hFFFE_0000};
  logic [W-1:0] dir_e[8] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF,
                             32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFD_0000, 32'hFFFD_0000};

  // reference model: exact product, round half up, clamp
  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    longint r;
    p = longint'($signed(x)) * longint'($signed(y));
    r = (p + 64'sd32768) >>> 16;
    if (r > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (r < -64'sd2147483648) return 32'h8000_0000;
    return r[31:0];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // driver: offer a pair, wait (bounded) for acceptance, push expected result
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, output int waits);
    waits = 0;
    @(negedge clk);
    a = x;
    b = y;
    valid_in = 1'b1;
    #1;
    while (!ready_out && waits < 60) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!ready_out) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got ready_out=0, expected 1 within 60 cycles");
    end else begin
      exp_q.push_back(model(x, y));
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    chk("drain_queue_empty", W'(exp_q.size()), '0);
  endtask

  // monitor: compare every output transfer, and hold-stability during stalls
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_stall = 1'b0;
      run_len = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", W'(valid_out), W'(1));
        chk("stall_result_held", result, prev_result);
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got result %h, expected no output", result);
        end else begin
          chk("result", result, exp_q.pop_front());
        end
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      prev_stall = valid_out && !ready_in;
      prev_result = result;
    end
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int tw;
    int w1;
    rst_n = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    a = '0;
    b = '0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready_out", W'(ready_out), '0);
    chk("reset_valid_out", W'(valid_out), '0);
    chk("reset_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // first product and its latency
    send(32'h0001_8000, 32'h0002_0000, w);
    idle();
    #1;
    chk("latency_edge1", W'(valid_out), '0);
    @(negedge clk);
    #1;
    chk("latency_edge2", W'(valid_out), '0);
    @(negedge clk);
    #1;
    chk("latency_edge3", W'(valid_out), W'(1));
    chk("first_result", result, 32'h0003_0000);
    drain();

    // directed rounding / saturation / sign cases
    for (int i = 0; i < 8; i++) begin
      send(dir_a[i], dir_b[i], w);
      idle();
      drain();
      chk($sformatf("directed_%0d", i), result, dir_e[i]);
    end

    // streaming at full rate
    max_run = 0;
    tw = 0;
    for (int k = 1; k <= 8; k++) begin
      send(W'(k), 32'h0001_0000, w);
      tw += w;
    end
    idle();
    drain();
    chk("stream_no_wait", W'(tw), '0);
    chk("stream_consecutive", W'(max_run >= 8), W'(1));
    chk("stream_last", result, 32'h0000_0008);

    // backpressure: fill all stages, then release
    @(negedge clk);
    ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(W'(32'h0001_0000 * (k + 1)), 32'h0000_8000, w);
    end
    idle();
    #1;
    chk("bp_ready_out_low", W'(ready_out), '0);
    chk("bp_valid_out", W'(valid_out), W'(1));
    fork
      begin
        for (int k = 3; k < 6; k++) begin
          send(W'(32'h0001_0000 * (k + 1)), 32'h0000_8000, w1);
        end
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        ready_in = 1'b1;
      end
    join
    drain();

    // randomized traffic with random downstream stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          logic [W-1:0] x;
          logic [W-1:0] y;
          case ($urandom_range(0, 2))
            0: begin x = $urandom; y = $urandom; end
            1: begin x = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
                     y = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000; end
            default: begin x = $urandom; y = $urandom_range(0, 32'h0001_0000); end
          endcase
          send(x, y, w1);
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          ready_in = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clk);
    ready_in = 1'b1;
    drain();

    // reset with two products in flight
    send(32'h0005_0000, 32'h0002_0000, w);
    send(32'h0007_0000, 32'h0002_0000, w);
    @(negedge clk);
    valid_in = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midreset_ready_out", W'(ready_out), '0);
    @(negedge clk);
    #1;
    chk("midreset_valid_out", W'(valid_out), '0);
    chk("midreset_result", result, '0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("post_reset_no_stale", W'(valid_out), '0);
    end

    // pipeline still works after reset
    send(32'h0003_0000, 32'hFFFF_0000, w);
    idle();
    drain();
    chk("post_reset_result", result, 32'hFFFD_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
